fas_issue_arbiter: RTL

//  Shares one FP add/sub pipeline (stage-1 operand format {s1, exp9, sig32}) between two requesters.

---
 rtl/fas_pkg.sv | 33 +++
 rtl/fas_tag_fifo.sv | 55 +++++
 rtl/fas_issue_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fas_pkg.sv
// Shared operand format and helpers for the FP add/sub issue path.
// Operands are {sign, exp[8:0], sig[31:0]}, the stage-1 input format of the pipeline.
package fas_pkg;

  localparam int FAS_OPW  = 42;
  localparam int FAS_EXPW = 9;
  localparam int FAS_SIGW = 32;

  localparam int S_BIT  = 41;
  localparam int EXP_HI = 40;
  localparam int EXP_LO = 32;
  localparam int SIG_HI = 31;

  typedef struct packed {
    logic                s;
    logic [FAS_EXPW-1:0] exp;
    logic [FAS_SIGW-1:0] sig;
  } fas_operand_t;

  // Subtraction is turned into addition by flipping the sign of B.
  function automatic fas_operand_t fas_negate(input fas_operand_t op, input logic sub);
    fas_operand_t r;
    r   = op;
    r.s = op.s ^ sub;
    return r;
  endfunction

  // Unsigned exponent compare; true only when y strictly exceeds x.
  function automatic logic fas_exp_gt(input fas_operand_t y, input fas_operand_t x);
    return (y.exp > x.exp);
  endfunction

endpackage

// File: rtl/fas_tag_fifo.sv
// Synchronous FIFO holding the owner id of each operation in flight in the pipeline.
// Pointers carry an extra wrap bit so full and empty are told apart without a counter.
module fas_tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head    = r_mem[r_rptr[AW-1:0]];
  assign o_count   = r_wptr - r_rptr;

  // Pops of an empty FIFO and pushes into a full one are dropped, never corrupt pointers.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/fas_issue_arbiter.sv
// Two-requester round-robin issue front end for a shared FP add/sub pipeline.
// Handles credits, operand ordering (larger exponent to x0), subtract, and result routing by tag.
module fas_issue_arbiter
  import fas_pkg::*;
#(
  parameter int CREDITS   = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [41:0] req0_a,
  input  logic [41:0] req0_b,
  input  logic        req0_sub,
  input  logic        req0_credit,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [41:0] req1_a,
  input  logic [41:0] req1_b,
  input  logic        req1_sub,
  input  logic        req1_credit,
  output logic [41:0] fas_x0,
  output logic [41:0] fas_y0,
  output logic        fas_enable,
  input  logic        pipe_valid,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic        err_tag
);

  // Handshake: a request transfers on the cycle reqN_valid && reqN_ready; ready is
  // combinational from valid, credits and tag space, and at most one ready is high.

  localparam int          CW     = $clog2(TAG_DEPTH) + 1;
  localparam logic [3:0]  CRED_L = 4'(CREDITS);

  logic [3:0]    r_cnt0;
  logic [3:0]    r_cnt1;
  logic          r_rr;
  logic          r_enable;
  logic          r_id;
  logic [41:0]   r_x0;
  logic [41:0]   r_y0;
  logic          r_err;

  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_fifo_head;
  logic [CW-1:0] w_fifo_count;
  logic [CW:0]   w_occ;
  logic          w_full_next;
  logic          w_elig0;
  logic          w_elig1;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_gnt;
  logic          w_pop;

  fas_operand_t  w_sel_a;
  fas_operand_t  w_sel_b;
  fas_operand_t  w_neg_b;
  logic          w_sel_sub;
  logic          w_swap;
  logic          w_dec0;
  logic          w_dec1;

  fas_tag_fifo #(
    .WIDTH (1),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_enable),
    .i_data  (r_id),
    .i_pop   (w_pop),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (w_fifo_head),
    .o_count (w_fifo_count)
  );

  // The issue register pushes its tag this cycle, so it already occupies a FIFO slot.
  assign w_occ       = {1'b0, w_fifo_count} + (CW+1)'(r_enable);
  assign w_full_next = w_fifo_full || (w_occ >= (CW+1)'(TAG_DEPTH));

  assign w_elig0 = !rst && req0_valid && (r_cnt0 < CRED_L) && !w_full_next;
  assign w_elig1 = !rst && req1_valid && (r_cnt1 < CRED_L) && !w_full_next;

  assign w_gnt0 = w_elig0 && (!w_elig1 || (r_rr == 1'b0));
  assign w_gnt1 = w_elig1 && (!w_elig0 || (r_rr == 1'b1));
  assign w_gnt  = w_gnt0 || w_gnt1;

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  always_comb begin
    w_sel_a   = fas_operand_t'(req0_a);
    w_sel_b   = fas_operand_t'(req0_b);
    w_sel_sub = req0_sub;
    if (w_gnt1) begin
      w_sel_a   = fas_operand_t'(req1_a);
      w_sel_b   = fas_operand_t'(req1_b);
      w_sel_sub = req1_sub;
    end
  end

  assign w_neg_b = fas_negate(w_sel_b, w_sel_sub);
  assign w_swap  = fas_exp_gt(w_neg_b, w_sel_a);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_enable <= 1'b0;
      r_id     <= 1'b0;
      r_x0     <= '0;
      r_y0     <= '0;
      r_rr     <= 1'b0;
    end else begin
      r_enable <= w_gnt;
      if (w_gnt) begin
        r_id <= w_gnt1;
        r_rr <= !w_gnt1;
        if (w_swap) begin
          r_x0 <= w_neg_b;
          r_y0 <= w_sel_a;
        end else begin
          r_x0 <= w_sel_a;
          r_y0 <= w_neg_b;
        end
      end
    end
  end

  assign fas_enable = r_enable;
  assign fas_x0     = r_x0;
  assign fas_y0     = r_y0;

  // Credit returns at zero are ignored so a stray pulse cannot wrap the counter.
  assign w_dec0 = req0_credit && (r_cnt0 != 4'd0);
  assign w_dec1 = req1_credit && (r_cnt1 != 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= 4'd0;
      r_cnt1 <= 4'd0;
    end else begin
      if (w_gnt0 && !w_dec0) begin
        r_cnt0 <= r_cnt0 + 4'd1;
      end else if (w_dec0 && !w_gnt0) begin
        r_cnt0 <= r_cnt0 - 4'd1;
      end
      if (w_gnt1 && !w_dec1) begin
        r_cnt1 <= r_cnt1 + 4'd1;
      end else if (w_dec1 && !w_gnt1) begin
        r_cnt1 <= r_cnt1 - 4'd1;
      end
    end
  end

  assign w_pop     = pipe_valid && !w_fifo_empty && !rst;
  assign rsp_valid = w_pop;
  assign rsp_id    = w_pop ? w_fifo_head : 1'b0;

  // A result with no tag in flight means the pipeline and this block have lost sync.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (pipe_valid && w_fifo_empty) begin
      r_err <= 1'b1;
    end
  end

  assign err_tag = r_err;

endmodule
